// File: rtl/touch_i2c_responder.sv
// I2C target model of a GT911-style touch controller with 16-bit register pointer.
// SCL/SDA are oversampled by clk; all state lives in the clk domain.
module touch_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h5D,
  parameter logic [15:0] INT_PULSE   = 16'd500,
  parameter logic [15:0] STATUS_ADDR = 16'h814E,
  parameter logic [15:0] COORD_ADDR  = 16'h8150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic        touch_valid,
  input  logic [11:0] touch_x,
  input  logic [11:0] touch_y,
  output logic        touch_int,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REGH, S_REGL, S_WDATA, S_RDATA, S_MACK, S_IGNORE
  } state_t;

  localparam logic [15:0] COORD_X_HI = COORD_ADDR + 16'd1;
  localparam logic [15:0] COORD_Y_LO = COORD_ADDR + 16'd2;
  localparam logic [15:0] COORD_Y_HI = COORD_ADDR + 16'd3;

  state_t      state_q, state_d;
  logic [2:0]  scl_sync_q, scl_sync_d;
  logic [2:0]  sda_sync_q, sda_sync_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] ptr_q, ptr_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic [7:0]  status_q, status_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [11:0] shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
  logic        pending_q, pending_d;
  logic [15:0] int_cnt_q, int_cnt_d;

  logic        scl_rise, scl_fall, start_det, stop_det, sda_bit;
  logic        addr_match, status_clr, direct_load, commit;
  logic [7:0]  rd_byte;

  assign scl_sync_d = {scl_sync_q[1:0], scl_in};
  assign sda_sync_d = {sda_sync_q[1:0], sda_in};
  assign scl_rise   = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall   = ~scl_sync_q[1] & scl_sync_q[2];
  assign start_det  = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
  assign stop_det   = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];
  assign sda_bit    = sda_sync_q[1];
  assign addr_match = (shift_q[7:1] == DEV_ADDR);

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign touch_int = (int_cnt_q != 16'd0);

  always_comb begin
    rd_byte = 8'h00;
    if (ptr_q == STATUS_ADDR)     rd_byte = status_q;
    else if (ptr_q == COORD_ADDR) rd_byte = x_q[7:0];
    else if (ptr_q == COORD_X_HI) rd_byte = {4'h0, x_q[11:8]};
    else if (ptr_q == COORD_Y_LO) rd_byte = y_q[7:0];
    else if (ptr_q == COORD_Y_HI) rd_byte = {4'h0, y_q[11:8]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= 16'h0000;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      status_q   <= 8'h00;
      x_q        <= 12'h000;
      y_q        <= 12'h000;
      shadow_x_q <= 12'h000;
      shadow_y_q <= 12'h000;
      pending_q  <= 1'b0;
      int_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      status_q   <= status_d;
      x_q        <= x_d;
      y_q        <= y_d;
      shadow_x_q <= shadow_x_d;
      shadow_y_q <= shadow_y_d;
      pending_q  <= pending_d;
      int_cnt_q  <= int_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = S_ADDR;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_ADDR:     if (scl_fall && bit_cnt_q == 4'd8) state_d = addr_match ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: if (scl_fall && bit_cnt_q == 4'd9) state_d = shift_q[0] ? S_RDATA : S_REGH;
        S_REGH:     if (scl_fall && bit_cnt_q == 4'd9) state_d = S_REGL;
        S_REGL:     if (scl_fall && bit_cnt_q == 4'd9) state_d = S_WDATA;
        S_RDATA:    if (scl_fall && bit_cnt_q == 4'd8) state_d = S_MACK;
        S_MACK: begin
          if (scl_rise && bit_cnt_q == 4'd8 && sda_bit) state_d = S_IGNORE;
          else if (scl_fall && bit_cnt_q == 4'd9)       state_d = S_RDATA;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    status_d   = status_q;
    x_d        = x_q;
    y_d        = y_q;
    shadow_x_d = shadow_x_q;
    shadow_y_d = shadow_y_q;
    pending_d  = pending_q;
    int_cnt_d  = (int_cnt_q != 16'd0) ? int_cnt_q - 16'd1 : 16'd0;
    status_clr = 1'b0;

    if (start_det || stop_det) begin
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      if (stop_det) busy_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_REGH, S_REGL, S_WDATA: begin
          if (scl_rise) begin
            if (bit_cnt_q < 4'd8) begin
              shift_d   = {shift_q[6:0], sda_bit};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = 4'd9;
            end
          end
          if (scl_fall && bit_cnt_q == 4'd8) begin
            if (state_q == S_ADDR) begin
              sda_oe_d = addr_match;
              busy_d   = addr_match;
            end else begin
              sda_oe_d = 1'b1;
              case (state_q)
                S_REGH:  ptr_d[15:8] = shift_q;
                S_REGL:  ptr_d[7:0]  = shift_q;
                default: begin
                  status_clr = (ptr_q == STATUS_ADDR);
                  ptr_d      = ptr_q + 16'd1;
                end
              endcase
            end
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end
        end
        S_ADDR_ACK: begin
          if (scl_rise) bit_cnt_d = 4'd9;
          if (scl_fall && bit_cnt_q == 4'd9) begin
            bit_cnt_d = 4'd0;
            shift_d   = rd_byte;
            sda_oe_d  = shift_q[0] & ~rd_byte[7];
          end
        end
        S_RDATA: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        S_MACK: begin
          // Master ACK advances the pointer before the next byte is fetched.
          if (scl_rise && bit_cnt_q == 4'd8 && !sda_bit) begin
            ptr_d     = ptr_q + 16'd1;
            bit_cnt_d = 4'd9;
          end
          if (scl_fall && bit_cnt_q == 4'd9) begin
            bit_cnt_d = 4'd0;
            shift_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end

    // A touch arriving on the STOP cycle goes straight to the live registers.
    direct_load = touch_valid & (~busy_q | stop_det);
    commit      = stop_det & pending_q & ~touch_valid;
    if (status_clr) status_d = 8'h00;
    if (direct_load) begin
      x_d       = touch_x;
      y_d       = touch_y;
      status_d  = 8'h81;
      int_cnt_d = INT_PULSE;
      pending_d = 1'b0;
    end else if (touch_valid) begin
      shadow_x_d = touch_x;
      shadow_y_d = touch_y;
      pending_d  = 1'b1;
    end else if (commit) begin
      x_d       = shadow_x_q;
      y_d       = shadow_y_q;
      status_d  = 8'h81;
      int_cnt_d = INT_PULSE;
      pending_d = 1'b0;
    end
  end

endmodule
